slurm16_uart_rx: RTL and testbench

//   8-N-1 UART receiver; the receive-side counterpart of the SoC UART transmitter driven out on UART_TX.

---
 rtl/slurm16_uart_rx_pkg.sv | 24 ++
 rtl/slurm16_uart_rx_if.sv | 31 +++
 rtl/slurm16_uart_rx_fifo.sv | 53 +++++
 rtl/slurm16_uart_rx.sv | 156 +++++++++++++++
 tb/tb_slurm16_uart_rx.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/slurm16_uart_rx_pkg.sv
// ---------------------------------------------------------------------------
// slurm16_uart_pkg
//   Shared definitions for the slurm16 UART receive and transmit paths.
//   - rx_state_e : receiver frame FSM states
//   - calc_div   : rounded clocks-per-bit divisor from clock and baud rate
//   - DATA_BITS  : data bits per frame (8-N-1)
// ---------------------------------------------------------------------------
package slurm16_uart_pkg;

  localparam int unsigned DATA_BITS = 8;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_e;

  function automatic int unsigned calc_div(input int unsigned clock_freq,
                                           input int unsigned baud);
    return (clock_freq + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/slurm16_uart_rx_if.sv
// ---------------------------------------------------------------------------
// slurm16_uart_rx_if
//   CPU-side receive port of the UART.
//   rx_data   : byte at FIFO head (valid while rx_valid)
//   rx_valid  : FIFO non-empty
//   rx_ready  : consumer pops the head when rx_valid & rx_ready
//   frame_err : sticky framing-error flag
//   overrun   : sticky overrun flag
//   err_clear : clears both sticky flags
//   master = receiver side, slave = consumer side.
// ---------------------------------------------------------------------------
interface slurm16_uart_rx_if;
  import slurm16_uart_pkg::*;

  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 frame_err;
  logic                 overrun;
  logic                 err_clear;

  modport master (
    output rx_data, rx_valid, frame_err, overrun,
    input  rx_ready, err_clear
  );

  modport slave (
    input  rx_data, rx_valid, frame_err, overrun,
    output rx_ready, err_clear
  );
endinterface

// File: rtl/slurm16_uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// slurm16_sync_fifo
//   Single-clock FIFO with registered storage and combinational head read.
//   clk_i, rst_i : clock, async active-high reset (empties the FIFO)
//   push_i/data_i: write request and data (dropped when full unless popping)
//   pop_i        : consume head (ignored when empty)
//   data_o       : head entry
//   full_o/empty_o: status
// ---------------------------------------------------------------------------
module slurm16_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LOG2  = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned DEPTH = 2 ** LOG2;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [LOG2:0]    wr_ptr_q, rd_ptr_q;
  logic             do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[LOG2] != rd_ptr_q[LOG2]) &&
                   (wr_ptr_q[LOG2-1:0] == rd_ptr_q[LOG2-1:0]);
  assign data_o  = mem_q[rd_ptr_q[LOG2-1:0]];

  assign do_pop  = pop_i & ~empty_o;
  // A pop in the same cycle frees the slot the push lands in.
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q[LOG2-1:0]] <= data_i;
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

endmodule

// File: rtl/slurm16_uart_rx.sv
// ---------------------------------------------------------------------------
// slurm16_uart_rx
//   8-N-1 UART receiver with mid-bit sampling, receive FIFO and sticky
//   framing/overrun flags.
//   clk_i     : system clock
//   rst_i     : async active-high reset
//   uart_rx_i : asynchronous serial input, idles high
//   bus       : CPU-side receive port (master modport)
// ---------------------------------------------------------------------------
module slurm16_uart_rx
  import slurm16_uart_pkg::*;
#(
  parameter int unsigned CLOCK_FREQ = 12000000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned FIFO_LOG2  = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               uart_rx_i,
  slurm16_uart_rx_if.master  bus
);

  localparam int unsigned DIV = calc_div(CLOCK_FREQ, BAUD);
  localparam int unsigned CW  = $clog2(DIV);
  localparam logic [CW-1:0] HALF_LOAD = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(DIV - 1);

  rx_state_e            state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2:0]           idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 brk_q, brk_d;
  logic                 sync1_q, rx_s_q;
  logic                 ferr_q, ovr_q;
  logic                 push, ferr_set, ovr_set;
  logic                 fifo_full, fifo_empty;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
    end else begin
      sync1_q <= uart_rx_i;
      rx_s_q  <= sync1_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      brk_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      brk_q   <= brk_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    brk_d    = brk_q;
    push     = 1'b0;
    ferr_set = 1'b0;
    unique case (state_q)
      IDLE: begin
        // After a framing error the line must be seen high before the
        // next start, so a held break reports only once.
        if (brk_q) begin
          if (rx_s_q) brk_d = 1'b0;
        end else if (!rx_s_q) begin
          cnt_d   = HALF_LOAD;
          state_d = START;
        end
      end
      START: begin
        if (cnt_q == '0) begin
          if (!rx_s_q) begin
            cnt_d   = FULL_LOAD;
            idx_d   = '0;
            state_d = DATA;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == '0) begin
          shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
          cnt_d   = FULL_LOAD;
          if (idx_q == 3'(DATA_BITS - 1)) state_d = STOP;
          else                            idx_d   = idx_q + 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          if (rx_s_q) begin
            push = 1'b1;
          end else begin
            ferr_set = 1'b1;
            brk_d    = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Full FIFO is never empty, so rx_ready alone means the pop takes effect.
  assign ovr_set = push & fifo_full & ~bus.rx_ready;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ferr_q <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      if (ferr_set)           ferr_q <= 1'b1;
      else if (bus.err_clear) ferr_q <= 1'b0;
      if (ovr_set)            ovr_q  <= 1'b1;
      else if (bus.err_clear) ovr_q  <= 1'b0;
    end
  end

  slurm16_sync_fifo #(
    .WIDTH (DATA_BITS),
    .LOG2  (FIFO_LOG2)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .data_i  (shift_q),
    .pop_i   (bus.rx_ready),
    .data_o  (bus.rx_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign bus.rx_valid  = ~fifo_empty;
  assign bus.frame_err = ferr_q;
  assign bus.overrun   = ovr_q;

endmodule

// File: tb/tb_slurm16_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_slurm16_uart_rx
//   Self-checking bench for slurm16_uart_rx at default parameters
//   (104 clocks per bit). Expected FIFO contents and flags come from a
//   queue-based model of the receive port.
// ---------------------------------------------------------------------------
module tb_slurm16_uart_rx;

  localparam int unsigned BIT   = 104;
  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx_line = 1'b1;

  slurm16_uart_rx_if bus ();

  slurm16_uart_rx #(
    .CLOCK_FREQ (12000000),
    .BAUD       (115200),
    .FIFO_LOG2  (2)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .uart_rx_i (rx_line),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] model_q[$];
  bit         m_ferr = 1'b0;
  bit         m_ovr  = 1'b0;

  typedef struct {
    logic [7:0]  data;
    int unsigned per;
    bit          stop_ok;
    bit          exp_valid;
    logic [7:0]  exp_data;
    bit          exp_ferr;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance n rising edges and land 1 time unit after the last one.
  task automatic step(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input int unsigned per, input bit stop_ok);
    rx_line = 1'b0;
    step(per);
    for (int i = 0; i < 8; i++) begin
      rx_line = b[i];
      step(per);
    end
    rx_line = stop_ok;
    step(per);
    if (!stop_ok) begin
      rx_line = 1'b1;
      step(4);
    end
  endtask

  task automatic model_rx(input logic [7:0] b);
    if (model_q.size() < DEPTH) model_q.push_back(b);
    else                        m_ovr = 1'b1;
  endtask

  task automatic compare_state(input string tag);
    check({tag, ".valid"}, {31'd0, bus.rx_valid}, {31'd0, model_q.size() != 0});
    if (model_q.size() != 0)
      check({tag, ".data"}, {24'd0, bus.rx_data}, {24'd0, model_q[0]});
    check({tag, ".ferr"}, {31'd0, bus.frame_err}, {31'd0, m_ferr});
    check({tag, ".ovr"}, {31'd0, bus.overrun}, {31'd0, m_ovr});
  endtask

  task automatic pop_one(input string tag);
    check({tag, ".pop_valid"}, {31'd0, bus.rx_valid}, 32'd1);
    check({tag, ".pop_data"}, {24'd0, bus.rx_data}, {24'd0, model_q[0]});
    bus.rx_ready = 1'b1;
    step(1);
    bus.rx_ready = 1'b0;
    void'(model_q.pop_front());
  endtask

  task automatic clear_flags();
    bus.err_clear = 1'b1;
    step(1);
    bus.err_clear = 1'b0;
    m_ferr = 1'b0;
    m_ovr  = 1'b0;
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [7:0] b;
    int unsigned per;
    bit ok;
    int unsigned npop;

    bus.rx_ready  = 1'b0;
    bus.err_clear = 1'b0;

    vecs[0] = '{8'hA5, 104, 1'b1, 1'b1, 8'hA5, 1'b0};
    vecs[1] = '{8'h00, 102, 1'b1, 1'b1, 8'h00, 1'b0};
    vecs[2] = '{8'h00, 106, 1'b1, 1'b1, 8'h00, 1'b0};
    vecs[3] = '{8'h3C, 104, 1'b0, 1'b0, 8'h00, 1'b1};
    vecs[4] = '{8'h55, 104, 1'b1, 1'b1, 8'h55, 1'b0};
    vecs[5] = '{8'hFF, 106, 1'b1, 1'b1, 8'hFF, 1'b0};
    vecs[6] = '{8'h7E, 102, 1'b1, 1'b1, 8'h7E, 1'b0};

    // Reset state
    step(3);
    check("reset.valid", {31'd0, bus.rx_valid}, 32'd0);
    check("reset.data", {24'd0, bus.rx_data}, 32'd0);
    check("reset.ferr", {31'd0, bus.frame_err}, 32'd0);
    check("reset.ovr", {31'd0, bus.overrun}, 32'd0);
    rst = 1'b0;
    step(10);

    // First frame: latency from falling edge to rx_valid
    lat = 0;
    fork
      send_frame(8'hA5, BIT, 1'b1);
      begin
        for (int n = 1; n <= 1200; n++) begin
          step(1);
          if (bus.rx_valid && lat == 0) lat = n;
        end
      end
    join
    check("lat.cycles", lat, 2 + 52 + 9 * 104 + 1);
    model_rx(8'hA5);
    compare_state("lat");
    pop_one("lat");

    // Short glitch on idle line
    rx_line = 1'b0;
    step(2);
    rx_line = 1'b1;
    step(200);
    compare_state("glitch");

    // Table of frames, including baud skew and a bad stop bit
    for (int v = 0; v < 7; v++) begin
      send_frame(vecs[v].data, vecs[v].per, vecs[v].stop_ok);
      step(2);
      check($sformatf("vec%0d.valid", v), {31'd0, bus.rx_valid}, {31'd0, vecs[v].exp_valid});
      if (vecs[v].exp_valid)
        check($sformatf("vec%0d.data", v), {24'd0, bus.rx_data}, {24'd0, vecs[v].exp_data});
      check($sformatf("vec%0d.ferr", v), {31'd0, bus.frame_err}, {31'd0, vecs[v].exp_ferr});
      check($sformatf("vec%0d.ovr", v), {31'd0, bus.overrun}, 32'd0);
      if (vecs[v].exp_valid) begin
        bus.rx_ready = 1'b1;
        step(1);
        bus.rx_ready = 1'b0;
      end
      clear_flags();
      check($sformatf("vec%0d.clr", v), {31'd0, bus.frame_err}, 32'd0);
    end

    // Held break: exactly one framing error, then recovery
    rx_line = 1'b0;
    step(BIT);
    for (int i = 0; i < 8; i++) begin
      rx_line = (8'h3C >> i) & 1'b1;
      step(BIT);
    end
    rx_line = 1'b0;
    step(BIT + 1000);
    m_ferr = 1'b1;
    compare_state("brk.set");
    clear_flags();
    step(1500);
    compare_state("brk.held");
    rx_line = 1'b1;
    step(10);
    send_frame(8'h55, BIT, 1'b1);
    model_rx(8'h55);
    compare_state("brk.after");
    pop_one("brk.after");

    // Overrun: five bytes without popping
    for (int i = 1; i <= 5; i++) begin
      send_frame(8'(i), BIT, 1'b1);
      model_rx(8'(i));
    end
    compare_state("ovr");
    for (int i = 0; i < 4; i++) pop_one("ovr");
    compare_state("ovr.empty");
    clear_flags();

    // Pop in the same cycle as a push into a full FIFO
    for (int i = 1; i <= 4; i++) begin
      send_frame(8'(i), BIT, 1'b1);
      model_rx(8'(i));
    end
    fork
      send_frame(8'h05, BIT, 1'b1);
      begin
        step(990);
        bus.rx_ready = 1'b1;
        step(1);
        bus.rx_ready = 1'b0;
      end
    join
    void'(model_q.pop_front());
    model_rx(8'h05);
    compare_state("simul");
    for (int i = 0; i < 4; i++) pop_one("simul");
    compare_state("simul.empty");

    // Reset in the middle of bit 4, with a byte queued and a flag set
    send_frame(8'h11, BIT, 1'b1);
    send_frame(8'h22, BIT, 1'b0);
    rx_line = 1'b0;
    step(BIT);
    for (int i = 0; i < 4; i++) begin
      rx_line = (8'hC3 >> i) & 1'b1;
      step(BIT);
    end
    rx_line = (8'hC3 >> 4) & 1'b1;
    step(52);
    rst = 1'b1;
    step(2);
    model_q.delete();
    m_ferr = 1'b0;
    m_ovr  = 1'b0;
    check("rst.valid", {31'd0, bus.rx_valid}, 32'd0);
    check("rst.data", {24'd0, bus.rx_data}, 32'd0);
    compare_state("rst");
    rx_line = 1'b1;
    rst = 1'b0;
    step(20);
    send_frame(8'h7E, BIT, 1'b1);
    model_rx(8'h7E);
    compare_state("rst.after");
    pop_one("rst.after");

    // Randomized traffic against the model
    for (int it = 0; it < 14; it++) begin
      b   = 8'($urandom);
      per = $urandom_range(102, 106);
      ok  = ($urandom_range(0, 7) != 0);
      send_frame(b, per, ok);
      if (ok) model_rx(b);
      else    m_ferr = 1'b1;
      compare_state($sformatf("rand%0d", it));
      npop = $urandom_range(0, 2);
      for (int k = 0; k < int'(npop); k++)
        if (model_q.size() != 0) pop_one($sformatf("rand%0d", it));
      if ($urandom_range(0, 3) == 0) clear_flags();
      step($urandom_range(0, 15));
    end
    while (model_q.size() != 0) pop_one("drain");
    compare_state("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
